// File: rtl/adc_spi_cmd_pkg.sv
// Shared definitions for the ADC SPI command serializer: FSM state encoding
// and the SPI mode-0 polarity constants.
package adc_spi_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_HOLD     = 3'd4,
        ST_GAP      = 3'd5
    } state_t;

    localparam logic SCK_IDLE  = 1'b0;
    localparam logic CS_ACTIVE = 1'b0;

endpackage

// File: rtl/adc_spi_clkgen.sv
// SCK half-period timer: a down-counter reloaded at every phase start,
// emitting a one-cycle tick on the last cycle of each half-period.
module adc_spi_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic i_en,
    input  logic i_load,
    output logic o_tick
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_LOAD;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/adc_spi_cmd.sv
// AXI4-Stream to ADC SPI register-port serializer (mode 0, MSB first).
// Readback capture into rx_data/rx_valid is built only with ADC_SPI_RX_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | tready high, csn high; waiting for a command word
// SETUP    | csn low, first bit on sdo, sck low for one half-period
// SHIFT_HI | sck high; sdi sampled on entry
// SHIFT_LO | sck low; next bit already on sdo
// HOLD     | sck low for one half-period before csn rises
// GAP      | csn high for CS_GAP cycles before the next accept
module adc_spi_cmd
    import adc_spi_cmd_pkg::*;
#(
    parameter int FRAME_BITS = 24,
    parameter int CLK_DIV    = 4,
    parameter int CS_GAP     = 8
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic        spi_csn,
    output logic        spi_sck,
    output logic        spi_sdo,
    input  logic        spi_sdi,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        busy
);

    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam int GAP_W = $clog2(CS_GAP + 1);

    state_t                r_state, w_state_nxt;
    logic                  r_csn, w_csn_nxt;
    logic                  r_sck, w_sck_nxt;
    logic                  r_sdo, w_sdo_nxt;
    logic                  r_tready, w_tready_nxt;
    logic                  r_busy, w_busy_nxt;
    logic [FRAME_BITS-1:0] r_tx_sr, w_tx_sr_nxt, w_tx_shift;
    logic [BIT_W-1:0]      r_bit_cnt, w_bit_cnt_nxt;
    logic [GAP_W-1:0]      r_gap_cnt, w_gap_cnt_nxt;
    logic                  w_tick, w_load, w_en;
    logic                  w_sample, w_frame_done;
    logic                  w_unused_bits;

    assign w_en = (r_state == ST_SETUP) || (r_state == ST_SHIFT_HI) ||
                  (r_state == ST_SHIFT_LO) || (r_state == ST_HOLD);

    adc_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_en    (w_en),
        .i_load  (w_load),
        .o_tick  (w_tick)
    );

    assign w_tx_shift = r_tx_sr << 1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= ST_IDLE;
            r_csn     <= ~CS_ACTIVE;
            r_sck     <= SCK_IDLE;
            r_sdo     <= 1'b0;
            r_tready  <= 1'b0;
            r_busy    <= 1'b0;
            r_tx_sr   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_csn     <= w_csn_nxt;
            r_sck     <= w_sck_nxt;
            r_sdo     <= w_sdo_nxt;
            r_tready  <= w_tready_nxt;
            r_busy    <= w_busy_nxt;
            r_tx_sr   <= w_tx_sr_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_csn_nxt     = r_csn;
        w_sck_nxt     = r_sck;
        w_sdo_nxt     = r_sdo;
        w_tx_sr_nxt   = r_tx_sr;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_load        = 1'b0;
        w_sample      = 1'b0;
        w_frame_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_csn_nxt = ~CS_ACTIVE;
                w_sck_nxt = SCK_IDLE;
                if (s_axis_tvalid && r_tready) begin
                    w_tx_sr_nxt   = s_axis_tdata[FRAME_BITS-1:0];
                    w_bit_cnt_nxt = '0;
                    w_csn_nxt     = CS_ACTIVE;
                    w_sdo_nxt     = s_axis_tdata[FRAME_BITS-1];
                    w_load        = 1'b1;
                    w_state_nxt   = ST_SETUP;
                end
            end
            ST_SETUP, ST_SHIFT_LO: begin
                if (w_tick) begin
                    w_sck_nxt     = ~SCK_IDLE;
                    w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                    w_sample      = 1'b1;
                    w_load        = 1'b1;
                    w_state_nxt   = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (w_tick) begin
                    w_sck_nxt = SCK_IDLE;
                    w_load    = 1'b1;
                    if (r_bit_cnt == BIT_W'(FRAME_BITS)) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_tx_sr_nxt = w_tx_shift;
                        w_sdo_nxt   = w_tx_shift[FRAME_BITS-1];
                        w_state_nxt = ST_SHIFT_LO;
                    end
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
                    w_csn_nxt     = ~CS_ACTIVE;
                    w_sdo_nxt     = 1'b0;
                    w_gap_cnt_nxt = GAP_W'(CS_GAP - 1);
                    w_frame_done  = 1'b1;
                    w_state_nxt   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_csn_nxt   = ~CS_ACTIVE;
                w_sck_nxt   = SCK_IDLE;
                w_sdo_nxt   = 1'b0;
            end
        endcase
        w_tready_nxt = (w_state_nxt == ST_IDLE);
        w_busy_nxt   = (w_state_nxt != ST_IDLE);
    end

`ifdef ADC_SPI_RX_EN
    logic [FRAME_BITS-1:0] r_rx_sr;
    logic [31:0]           r_rx_data;
    logic                  r_rx_valid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rx_sr    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= w_frame_done;
            if (w_sample) begin
                r_rx_sr <= (r_rx_sr << 1) | FRAME_BITS'(spi_sdi);
            end
            if (w_frame_done) begin
                r_rx_data <= 32'(r_rx_sr);
            end
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign w_unused_bits = ^s_axis_tdata;
`else
    assign rx_data       = '0;
    assign rx_valid      = 1'b0;
    assign w_unused_bits = ^{s_axis_tdata, spi_sdi, w_sample, w_frame_done};
`endif

    assign s_axis_tready = r_tready;
    assign spi_csn       = r_csn;
    assign spi_sck       = r_sck;
    assign spi_sdo       = r_sdo;
    assign busy          = r_busy;

endmodule
